// File: rtl/axi_burst_slave.sv
// Burst-capable AXI-style slave backed by a DEPTH-word register file.
// Independent read (AR/R) and write (AW/W/B) channels, each with a latency
// that is captured at the address handshake. Addresses wrap modulo DEPTH.
// Out-of-range start addresses and wlast/awlen disagreements return SLVERR.
module axi_burst_slave #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 16,
  parameter int LEN_W   = 4,
  parameter int DELAY_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DELAY_W-1:0] delay,
  input  logic               arvalid,
  output logic               arready,
  input  logic [ADDR_W-1:0]  araddr,
  input  logic [LEN_W-1:0]   arlen,
  output logic               rvalid,
  input  logic               rready,
  output logic [DATA_W-1:0]  rdata,
  output logic [1:0]         rresp,
  output logic               rlast,
  input  logic               awvalid,
  output logic               awready,
  input  logic [ADDR_W-1:0]  awaddr,
  input  logic [LEN_W-1:0]   awlen,
  input  logic               wvalid,
  output logic               wready,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               wlast,
  output logic               bvalid,
  input  logic               bready,
  output logic [1:0]         bresp,
  output logic               ridle,
  output logic               widle
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DEPTH - 1);
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;

  // Next storage index with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  r_state_e          r_state_q, r_state_d;
  logic [DELAY_W-1:0] r_cnt_q, r_cnt_d;
  logic [LEN_W-1:0]  r_len_q, r_len_d;
  logic [LEN_W-1:0]  r_beat_q, r_beat_d;
  logic [IDX_W-1:0]  r_idx_q, r_idx_d;
  logic              r_err_q, r_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              r_load;

  w_state_e          w_state_q, w_state_d;
  logic [DELAY_W-1:0] w_cnt_q, w_cnt_d;
  logic [DELAY_W-1:0] w_delay_q, w_delay_d;
  logic [LEN_W-1:0]  w_len_q, w_len_d;
  logic [LEN_W-1:0]  w_beat_q, w_beat_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic              w_err_q, w_err_d;
  logic              w_slverr_q, w_slverr_d;
  logic              w_at_len;

  // Storage: written by the write channel only; reads sample the pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the store must come up cleared, so every word is reset here;
      // this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read channel next-state: address capture, latency count, beat sequencing.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_idx_d   = r_idx_q;
    r_err_d   = r_err_q;
    r_load    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_len_d  = arlen;
          r_beat_d = '0;
          r_idx_d  = IDX_W'(araddr);
          r_err_d  = ({1'b0, araddr} >= DEPTH_LIM);
          r_cnt_d  = delay;
          if (delay == '0) begin
            r_state_d = R_DATA;
            r_load    = 1'b1;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_q != '0) r_cnt_d = r_cnt_q - DELAY_W'(1);
        if (r_cnt_q <= DELAY_W'(1)) begin
          r_state_d = R_DATA;
          r_load    = 1'b1;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_beat_d = r_beat_q + LEN_W'(1);
            r_idx_d  = idx_inc(r_idx_q);
            r_load   = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Data is captured when a beat is presented, so it stays stable through
    // stalls and a same-edge write to that word is not seen (read-before-write).
    rdata_d = rdata_q;
    if (r_load) rdata_d = r_err_d ? '0 : mem_q[r_idx_d];
  end

  // Read channel state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_idx_q   <= '0;
      r_err_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_idx_q   <= r_idx_d;
      r_err_q   <= r_err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign w_at_len = (w_beat_q == w_len_q);

  // Write channel next-state: address capture, data beats, latency, response.
  always_comb begin
    w_state_d  = w_state_q;
    w_cnt_d    = w_cnt_q;
    w_delay_d  = w_delay_q;
    w_len_d    = w_len_q;
    w_beat_d   = w_beat_q;
    w_idx_d    = w_idx_q;
    w_err_d    = w_err_q;
    w_slverr_d = w_slverr_q;
    mem_we     = 1'b0;
    mem_waddr  = w_idx_q;
    mem_wdata  = wdata;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid) begin
          w_len_d    = awlen;
          w_beat_d   = '0;
          w_idx_d    = IDX_W'(awaddr);
          w_err_d    = ({1'b0, awaddr} >= DEPTH_LIM);
          w_slverr_d = ({1'b0, awaddr} >= DEPTH_LIM);
          w_delay_d  = delay;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          mem_we = !w_err_q;
          // Burst ends on wlast or on beat awlen; disagreement is an error.
          if (wlast || w_at_len) begin
            if (wlast != w_at_len) w_slverr_d = 1'b1;
            if (w_delay_q == '0) begin
              w_state_d = W_RESP;
            end else begin
              w_cnt_d   = w_delay_q;
              w_state_d = W_WAIT;
            end
          end else begin
            w_beat_d = w_beat_q + LEN_W'(1);
            w_idx_d  = idx_inc(w_idx_q);
          end
        end
      end
      W_WAIT: begin
        if (w_cnt_q != '0) w_cnt_d = w_cnt_q - DELAY_W'(1);
        if (w_cnt_q <= DELAY_W'(1)) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q  <= W_IDLE;
      w_cnt_q    <= '0;
      w_delay_q  <= '0;
      w_len_q    <= '0;
      w_beat_q   <= '0;
      w_idx_q    <= '0;
      w_err_q    <= 1'b0;
      w_slverr_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      w_cnt_q    <= w_cnt_d;
      w_delay_q  <= w_delay_d;
      w_len_q    <= w_len_d;
      w_beat_q   <= w_beat_d;
      w_idx_q    <= w_idx_d;
      w_err_q    <= w_err_d;
      w_slverr_q <= w_slverr_d;
    end
  end

  assign ridle   = (r_state_q == R_IDLE);
  assign arready = ridle;
  assign rvalid  = (r_state_q == R_DATA);
  assign rdata   = rdata_q;
  assign rlast   = rvalid && (r_beat_q == r_len_q);
  assign rresp   = (rvalid && r_err_q) ? RESP_SLVERR : RESP_OKAY;

  assign widle   = (w_state_q == W_IDLE);
  assign awready = widle;
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = (bvalid && w_slverr_q) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_burst_slave.sv
// Directed bench for axi_burst_slave: latency, wrapping bursts, read stalls,
// error responses, concurrent channels and mid-burst reset.
module tb_axi_burst_slave;

  logic       clk;
  logic       rst;
  logic [4:0] delay;
  logic       arvalid, arready;
  logic [7:0] araddr;
  logic [3:0] arlen;
  logic       rvalid, rready;
  logic [7:0] rdata;
  logic [1:0] rresp;
  logic       rlast;
  logic       awvalid, awready;
  logic [7:0] awaddr;
  logic [3:0] awlen;
  logic       wvalid, wready;
  logic [7:0] wdata;
  logic       wlast;
  logic       bvalid, bready;
  logic [1:0] bresp;
  logic       ridle, widle;

  axi_burst_slave #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(16), .LEN_W(4), .DELAY_W(5)
  ) dut (
    .clk(clk), .rst(rst), .delay(delay),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .ridle(ridle), .widle(widle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] wr_dat [16];
  logic [1:0] wr_resp;
  int         wr_lat;

  logic [7:0] rd_data [16];
  logic [1:0] rd_resp [16];
  logic       rd_last [16];
  int         rd_n, rd_lat, rd_stab;
  logic       rd_after_valid;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Write burst: nbeats beats from wr_dat, wlast on beat wl_at (-1 = never).
  task automatic write_burst(input logic [7:0] addr, input logic [3:0] len,
                             input logic [4:0] dly, input int nbeats, input int wl_at);
    int n;
    awaddr = addr; awlen = len; delay = dly; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick; n++; end
    if (!awready) begin
      checks++; failures++;
      $display("FAIL awready_timeout: got %0b expected 1", awready);
    end
    tick;
    awvalid = 1'b0; delay = 5'd31; awaddr = 8'hFF;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = wr_dat[i]; wlast = (i == wl_at);
      n = 0;
      while (!wready && n < 50) begin tick; n++; end
      if (!wready) begin
        checks++; failures++;
        $display("FAIL wready_timeout beat %0d: got %0b expected 1", i, wready);
      end
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0;
    wr_lat = 0;
    while (!bvalid && wr_lat < 100) begin tick; wr_lat++; end
    wr_resp = bresp;
    bready = 1'b1;
    tick;
    bready = 1'b0;
  endtask

  // Read burst with rready following pat[cycle % 4]; records beats and stalls.
  task automatic read_burst(input logic [7:0] addr, input logic [3:0] len,
                            input logic [4:0] dly, input logic [3:0] pat);
    int n, cyc;
    logic prev_stall;
    logic [7:0] pd;
    logic [1:0] pr;
    logic pl;
    araddr = addr; arlen = len; delay = dly; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick; n++; end
    if (!arready) begin
      checks++; failures++;
      $display("FAIL arready_timeout: got %0b expected 1", arready);
    end
    tick;
    arvalid = 1'b0; delay = 5'd31; araddr = 8'hFF;
    rd_lat = 0;
    while (!rvalid && rd_lat < 100) begin tick; rd_lat++; end
    rd_n = 0; rd_stab = 0; cyc = 0; prev_stall = 1'b0;
    pd = '0; pr = '0; pl = 1'b0;
    while (rd_n < int'(len) + 1 && cyc < 200) begin
      rready = pat[cyc % 4];
      if (prev_stall && (!rvalid || rdata !== pd || rresp !== pr || rlast !== pl))
        rd_stab++;
      if (rvalid && rready) begin
        rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast;
        rd_n++;
      end
      prev_stall = rvalid && !rready;
      pd = rdata; pr = rresp; pl = rlast;
      tick;
      cyc++;
    end
    rready = 1'b0;
    rd_after_valid = rvalid;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) tick;
    checks++; if ({arready, awready} !== 2'b11) begin failures++;
      $display("FAIL reset_ready: got %b expected 11", {arready, awready}); end
    checks++; if ({ridle, widle} !== 2'b11) begin failures++;
      $display("FAIL reset_idle: got %b expected 11", {ridle, widle}); end
    checks++; if ({rvalid, rlast, wready, bvalid} !== 4'b0000) begin failures++;
      $display("FAIL reset_strobes: got %b expected 0000", {rvalid, rlast, wready, bvalid}); end
    checks++; if ({rdata, rresp, bresp} !== 12'h000) begin failures++;
      $display("FAIL reset_data: got %h expected 000", {rdata, rresp, bresp}); end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_latency;
    wr_dat[0] = 8'hA5;
    write_burst(8'd3, 4'd0, 5'd10, 1, 0);
    checks++; if (wr_lat != 10) begin failures++;
      $display("FAIL lat_bvalid: got %0d expected 10", wr_lat); end
    checks++; if (wr_resp !== 2'b00) begin failures++;
      $display("FAIL lat_bresp: got %b expected 00", wr_resp); end
    read_burst(8'd3, 4'd0, 5'd10, 4'b1111);
    checks++; if (rd_lat != 10) begin failures++;
      $display("FAIL lat_rvalid: got %0d expected 10", rd_lat); end
    checks++; if (rd_n != 1 || rd_data[0] !== 8'hA5 || rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00)
      begin failures++;
      $display("FAIL lat_rbeat: got n=%0d d=%h l=%b r=%b expected n=1 d=a5 l=1 r=00",
               rd_n, rd_data[0], rd_last[0], rd_resp[0]); end
    checks++; if (rd_after_valid !== 1'b0 || ridle !== 1'b1) begin failures++;
      $display("FAIL lat_rend: got rvalid=%b ridle=%b expected 0 1", rd_after_valid, ridle); end
  endtask

  task automatic test_burst_wrap;
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) wr_dat[i] = exp_d[i];
    write_burst(8'd14, 4'd3, 5'd0, 4, 3);
    checks++; if (wr_resp !== 2'b00 || wr_lat != 0) begin failures++;
      $display("FAIL wrap_bresp: got resp=%b lat=%0d expected 00 0", wr_resp, wr_lat); end
    read_burst(8'd14, 4'd3, 5'd0, 4'b1111);
    checks++; if (rd_n != 4 || rd_lat != 0) begin failures++;
      $display("FAIL wrap_rcount: got n=%0d lat=%0d expected 4 0", rd_n, rd_lat); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp_d[i] || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'b00) begin
        failures++;
        $display("FAIL wrap_beat%0d: got d=%h l=%b r=%b expected d=%h l=%b r=00",
                 i, rd_data[i], rd_last[i], rd_resp[i], exp_d[i], (i == 3));
      end
    end
    read_burst(8'd0, 4'd0, 5'd2, 4'b1111);
    checks++; if (rd_data[0] !== 8'h33 || rd_lat != 2) begin failures++;
      $display("FAIL wrap_addr0: got d=%h lat=%0d expected 33 2", rd_data[0], rd_lat); end
  endtask

  task automatic test_stall;
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    read_burst(8'd14, 4'd3, 5'd0, 4'b1001);
    checks++; if (rd_n != 4 || rd_stab != 0) begin failures++;
      $display("FAIL stall_count: got n=%0d unstable=%0d expected 4 0", rd_n, rd_stab); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp_d[i] || rd_last[i] !== (i == 3)) begin
        failures++;
        $display("FAIL stall_beat%0d: got d=%h l=%b expected d=%h l=%b",
                 i, rd_data[i], rd_last[i], exp_d[i], (i == 3));
      end
    end
    checks++; if (rd_after_valid !== 1'b0) begin failures++;
      $display("FAIL stall_end: got rvalid=%b expected 0", rd_after_valid); end
  endtask

  task automatic test_errors;
    // Out-of-range start address: no write, SLVERR.
    wr_dat[0] = 8'hEE; wr_dat[1] = 8'hEF;
    write_burst(8'd20, 4'd1, 5'd0, 2, 1);
    checks++; if (wr_resp !== 2'b10) begin failures++;
      $display("FAIL err_waddr_bresp: got %b expected 10", wr_resp); end
    read_burst(8'd4, 4'd1, 5'd0, 4'b1111);
    checks++; if (rd_data[0] !== 8'h00 || rd_data[1] !== 8'h00) begin failures++;
      $display("FAIL err_waddr_store: got %h %h expected 00 00", rd_data[0], rd_data[1]); end
    read_burst(8'd20, 4'd1, 5'd0, 4'b1111);
    checks++;
    if (rd_n != 2 || rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10 ||
        rd_data[0] !== 8'h00 || rd_data[1] !== 8'h00 || rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1) begin
      failures++;
      $display("FAIL err_raddr: got n=%0d r=%b/%b d=%h/%h l=%b/%b expected 2 10/10 00/00 0/1",
               rd_n, rd_resp[0], rd_resp[1], rd_data[0], rd_data[1], rd_last[0], rd_last[1]);
    end
    // Early wlast: burst ends after 2 of 4 beats, beats already written stay.
    wr_dat[0] = 8'h81; wr_dat[1] = 8'h82;
    write_burst(8'd8, 4'd3, 5'd0, 2, 1);
    checks++; if (wr_resp !== 2'b10 || widle !== 1'b1) begin failures++;
      $display("FAIL err_early_bresp: got resp=%b widle=%b expected 10 1", wr_resp, widle); end
    read_burst(8'd8, 4'd3, 5'd0, 4'b1111);
    checks++;
    if (rd_data[0] !== 8'h81 || rd_data[1] !== 8'h82 || rd_data[2] !== 8'h00 || rd_data[3] !== 8'h00) begin
      failures++;
      $display("FAIL err_early_store: got %h %h %h %h expected 81 82 00 00",
               rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
    end
    // Missing wlast on beat awlen: burst still ends there, SLVERR.
    wr_dat[0] = 8'h91; wr_dat[1] = 8'h92;
    write_burst(8'd12, 4'd1, 5'd0, 2, -1);
    checks++; if (wr_resp !== 2'b10) begin failures++;
      $display("FAIL err_nolast_bresp: got %b expected 10", wr_resp); end
    read_burst(8'd12, 4'd1, 5'd0, 4'b1111);
    checks++; if (rd_data[0] !== 8'h91 || rd_data[1] !== 8'h92) begin failures++;
      $display("FAIL err_nolast_store: got %h %h expected 91 92", rd_data[0], rd_data[1]); end
  endtask

  task automatic test_concurrent;
    awaddr = 8'd5; awlen = 4'd0; araddr = 8'd5; arlen = 4'd0; delay = 5'd0;
    awvalid = 1'b1; arvalid = 1'b1;
    tick;
    awvalid = 1'b0; arvalid = 1'b0;
    checks++; if ({ridle, widle, rvalid, wready} !== 4'b0011) begin failures++;
      $display("FAIL conc_start: got ridle,widle,rvalid,wready=%b expected 0011",
               {ridle, widle, rvalid, wready}); end
    wvalid = 1'b1; wdata = 8'h7E; wlast = 1'b1; rready = 1'b1;
    checks++; if (rdata !== 8'h00 || rlast !== 1'b1) begin failures++;
      $display("FAIL conc_rdata_old: got d=%h l=%b expected 00 1", rdata, rlast); end
    tick;
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
    checks++; if ({ridle, rvalid, widle, bvalid, bresp} !== 6'b100100) begin failures++;
      $display("FAIL conc_split: got ridle,rvalid,widle,bvalid,bresp=%b expected 100100",
               {ridle, rvalid, widle, bvalid, bresp}); end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    checks++; if (widle !== 1'b1) begin failures++;
      $display("FAIL conc_widle: got %b expected 1", widle); end
    read_burst(8'd5, 4'd0, 5'd0, 4'b1111);
    checks++; if (rd_data[0] !== 8'h7E) begin failures++;
      $display("FAIL conc_rdata_new: got %h expected 7e", rd_data[0]); end
  endtask

  task automatic test_reset_midburst;
    araddr = 8'd3; arlen = 4'd0; delay = 5'd30; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    repeat (5) tick;
    checks++; if (ridle !== 1'b0 || rvalid !== 1'b0) begin failures++;
      $display("FAIL rstmid_wait: got ridle=%b rvalid=%b expected 0 0", ridle, rvalid); end
    rst = 1'b0;
    #1;
    checks++; if ({rvalid, arready, ridle} !== 3'b011) begin failures++;
      $display("FAIL rstmid_async: got rvalid,arready,ridle=%b expected 011",
               {rvalid, arready, ridle}); end
    tick;
    rst = 1'b1;
    tick;
    read_burst(8'd3, 4'd0, 5'd0, 4'b1111);
    checks++; if (rd_data[0] !== 8'h00 || rd_lat != 0) begin failures++;
      $display("FAIL rstmid_store3: got d=%h lat=%0d expected 00 0", rd_data[0], rd_lat); end
    read_burst(8'd5, 4'd0, 5'd0, 4'b1111);
    checks++; if (rd_data[0] !== 8'h00) begin failures++;
      $display("FAIL rstmid_store5: got %h expected 00", rd_data[0]); end
  endtask

  initial begin
    delay = '0; arvalid = 1'b0; araddr = '0; arlen = '0; rready = 1'b0;
    awvalid = 1'b0; awaddr = '0; awlen = '0; wvalid = 1'b0; wdata = '0;
    wlast = 1'b0; bready = 1'b0; rst = 1'b0;
    test_reset;
    test_latency;
    test_burst_wrap;
    test_stall;
    test_errors;
    test_concurrent;
    test_reset_midburst;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
